// File: rtl/echo_if.sv
// Sample stream handshake between source stage, echo block and mixer sum.
interface echo_if #(
  parameter int unsigned DATA_W = 24
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  // Driver/sink side (source stage feeding in, mixer consuming out)
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Echo block side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/echo_delay_line.sv
// Echo/delay effect: circular sample buffer with runtime delay length,
// optional feedback and dry/wet mix, behind a 1-entry output register.
module echo_delay_line #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned MAX_DEPTH = 1024,
  parameter int unsigned LEN_W     = 11,
  parameter int unsigned DRY_SHIFT = 3,
  parameter int unsigned WET_SHIFT = 3
) (
  input  logic             clk,
  input  logic             reset,
  echo_if.slave            bus,
  input  logic             on,
  input  logic             fb_en,
  input  logic [3:0]       fb_shift,
  input  logic [LEN_W-1:0] delay_len
);

  localparam int unsigned PTR_W = $clog2(MAX_DEPTH);
  localparam int unsigned EXT_W = DATA_W + 2;

  localparam logic signed [EXT_W-1:0] SAT_HI = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_LO = {3'b111, {(DATA_W-1){1'b0}}};
  localparam logic [LEN_W-1:0]        LEN_MAX = LEN_W'(MAX_DEPTH);

  logic signed [DATA_W-1:0] mem [MAX_DEPTH];

  logic signed [DATA_W-1:0] out_data_q;
  logic                     out_valid_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [LEN_W-1:0]         fill_q;

  logic                     acc;
  logic [LEN_W-1:0]         len_c;
  logic [PTR_W-1:0]         rd_ptr_c;
  logic signed [DATA_W-1:0] tap_c;
  logic signed [EXT_W-1:0]  in_ext;
  logic signed [EXT_W-1:0]  tap_ext;
  logic signed [EXT_W-1:0]  mix_ext;
  logic signed [EXT_W-1:0]  fb_ext;
  logic signed [DATA_W-1:0] mix_sat;
  logic signed [DATA_W-1:0] wr_data_c;

  // Clamp an extended-width value into the signed sample range
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [EXT_W-1:0] v);
    if (v > SAT_HI) begin
      sat = SAT_HI[DATA_W-1:0];
    end else if (v < SAT_LO) begin
      sat = SAT_LO[DATA_W-1:0];
    end else begin
      sat = v[DATA_W-1:0];
    end
  endfunction

  assign bus.in_ready  = ~out_valid_q | bus.out_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign acc           = bus.in_valid & bus.in_ready;

  // Delay clamp, tap read (stale entries masked by fill) and mix arithmetic
  always_comb begin
    len_c = delay_len;
    if (delay_len == '0) begin
      len_c = LEN_W'(1);
    end else if (delay_len > LEN_MAX) begin
      len_c = LEN_MAX;
    end

    // L = MAX_DEPTH wraps to rd_ptr == wr_ptr: the old entry is read before overwrite
    rd_ptr_c = wr_ptr_q - len_c[PTR_W-1:0];
    tap_c    = (fill_q >= len_c) ? mem[rd_ptr_c] : '0;

    in_ext  = {{2{bus.in_data[DATA_W-1]}}, bus.in_data};
    tap_ext = {{2{tap_c[DATA_W-1]}}, tap_c};

    mix_ext = (in_ext - (in_ext >>> DRY_SHIFT)) + (tap_ext >>> WET_SHIFT);
    fb_ext  = in_ext + (tap_ext >>> fb_shift);
    mix_sat = sat(mix_ext);

    wr_data_c = (on & fb_en) ? sat(fb_ext) : bus.in_data;
  end

  // Output register, write pointer and fill level advance per accepted sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
    end else if (acc) begin
      out_data_q  <= on ? mix_sat : bus.in_data;
      out_valid_q <= 1'b1;
      wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
      if (fill_q != LEN_MAX) begin
        fill_q <= fill_q + LEN_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sample buffer; contents survive reset, history is discarded through fill
  always_ff @(posedge clk) begin
    if (acc && !reset) begin
      mem[wr_ptr_q] <= wr_data_c;
    end
  end

endmodule

// File: tb/tb_echo_delay_line.sv
// Directed bench for echo_delay_line with hand-computed expected outputs.
module tb_echo_delay_line;

  logic        clk;
  logic        reset;
  logic        on;
  logic        fb_en;
  logic [3:0]  fb_shift;
  logic [10:0] delay_len;

  int checks;
  int errors;

  echo_if #(.DATA_W(24)) bus ();

  echo_delay_line #(
    .DATA_W(24), .MAX_DEPTH(1024), .LEN_W(11), .DRY_SHIFT(3), .WET_SHIFT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .on(on),
    .fb_en(fb_en),
    .fb_shift(fb_shift),
    .delay_len(delay_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 24'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic push_chk(input string tag, input int d, input int e);
    push(d);
    chk(tag, longint'(bus.out_data), longint'(e));
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int samples [6];
    int expv [6];
    int idx;
    int oidx;
    logic acc_now;
    logic stall;
    logic signed [23:0] held;

    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    on        = 1'b1;
    fb_en     = 1'b0;
    fb_shift  = 4'd0;
    delay_len = 11'd4;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_valid", longint'(bus.out_valid), 0);
    chk("rst_data", longint'(bus.out_data), 0);
    chk("rst_ready", longint'(bus.in_ready), 1);

    // Impulse, L=4, no feedback; idle cycle in the middle must not shift the echo
    push_chk("imp0", 800, 700);
    push_chk("imp1", 0, 0);
    push_chk("imp2", 0, 0);
    push_chk("imp3", 0, 0);
    push_chk("imp4", 0, 100);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", longint'(bus.out_valid), 0);
    chk("drain_data", longint'(bus.out_data), 100);
    push_chk("imp5", 0, 0);

    // Reset mid-stream discards in-flight output and echo history
    push_chk("pre0", 8000, 7000);
    push_chk("pre1", 8000, 7000);
    push_chk("pre2", 8000, 7000);
    push_chk("pre3", 8000, 7000);
    push_chk("pre4", 8000, 8000);
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_valid", longint'(bus.out_valid), 0);
    chk("midrst_data", longint'(bus.out_data), 0);
    @(negedge clk);
    reset = 1'b0;
    push_chk("post0", 800, 700);
    push_chk("post1", 800, 700);
    push_chk("post2", 800, 700);
    push_chk("post3", 800, 700);
    push_chk("post4", 800, 800);

    // Feedback: fb_shift=1, L=2
    do_reset();
    fb_en = 1'b1;
    fb_shift = 4'd1;
    delay_len = 11'd2;
    push_chk("fb0", 1024, 896);
    push_chk("fb1", 0, 0);
    push_chk("fb2", 0, 128);
    push_chk("fb3", 0, 0);
    push_chk("fb4", 0, 64);
    push_chk("fb5", 0, 0);
    push_chk("fb6", 0, 32);

    // Back-pressure: out_ready low for 5 cycles with input pending, L=1
    do_reset();
    fb_en = 1'b0;
    delay_len = 11'd1;
    samples = '{64, 128, 192, 256, 320, 384};
    expv    = '{56, 120, 184, 248, 312, 376};
    idx = 0;
    oidx = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      bus.in_valid  = (idx < 6);
      bus.in_data   = (idx < 6) ? 24'(samples[idx]) : '0;
      bus.out_ready = !(c >= 2 && c < 7);
      #1;
      acc_now = bus.in_valid & bus.in_ready;
      stall   = bus.out_valid & ~bus.out_ready;
      held    = bus.out_data;
      if (stall) chk("bp_ready_low", longint'(bus.in_ready), 0);
      if (bus.out_valid && bus.out_ready) begin
        if (oidx < 6) chk("bp_out", longint'(bus.out_data), longint'(expv[oidx]));
        else chk("bp_extra", longint'(oidx), 5);
        oidx++;
      end
      @(posedge clk);
      #1;
      if (stall) begin
        chk("bp_hold_data", longint'(bus.out_data), longint'(held));
        chk("bp_hold_valid", longint'(bus.out_valid), 1);
      end
      if (acc_now) idx++;
    end
    chk("bp_count", longint'(oidx), 6);
    bus.out_ready = 1'b1;

    // Saturation through feedback path, L=1, fb_shift=0
    do_reset();
    fb_en = 1'b1;
    fb_shift = 4'd0;
    delay_len = 11'd1;
    push_chk("satp0", 8388607, 7340032);
    push_chk("satp1", 8388607, 8388607);
    push_chk("satp2", 8388607, 8388607);
    push_chk("satp3", 8388607, 8388607);
    do_reset();
    push_chk("satn0", -8388608, -7340032);
    push_chk("satn1", -8388608, -8388608);
    push_chk("satn2", -8388608, -8388608);
    push_chk("satn3", -8388608, -8388608);

    // Bypass
    do_reset();
    on = 1'b0;
    fb_en = 1'b0;
    push_chk("byp0", 123, 123);
    push_chk("byp1", -456, -456);
    push_chk("byp2", 8388607, 8388607);

    // delay_len=0 behaves as 1
    do_reset();
    on = 1'b1;
    delay_len = 11'd0;
    push_chk("len0_a", 64, 56);
    push_chk("len0_b", 128, 120);

    // delay_len=2000 behaves as 1024
    do_reset();
    delay_len = 11'd2000;
    push_chk("len2k_0", 800, 700);
    for (int i = 1; i < 1023; i++) push(0);
    push_chk("len2k_1023", 0, 0);
    push_chk("len2k_1024", 0, 100);
    push_chk("len2k_1025", 0, 0);

    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
